// File: rtl/shift_add_mul.sv
// Sequential shift-and-add unsigned multiplier with a start/busy/done handshake.
// Define SHIFT_ADD_MUL_EARLY_EXIT_EN to end a run once no set multiplier bits remain.
module shift_add_mul #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prdct
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   sum;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;
  logic                 finish;

  assign addend = mplier[0] ? mcand : '0;
  assign sum    = acc + addend;

`ifdef SHIFT_ADD_MUL_EARLY_EXIT_EN
  // Stop as soon as the bit being consumed is the last set bit of the multiplier.
  assign finish = (cnt == CNT_W'(WIDTH-1)) || ((mplier >> 1) == '0);
`else
  assign finish = (cnt == CNT_W'(WIDTH-1));
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      prdct  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // The final partial sum goes straight to prdct so it changes only on completion.
          if (finish) begin
            prdct <= sum;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mul.sv
// Directed bench for shift_add_mul: vector table plus back-to-back, busy-start and reset-abort sequences.
// Latency expectations follow SHIFT_ADD_MUL_EARLY_EXIT_EN when it is defined for the build.
module tb_shift_add_mul;

  localparam int WIDTH = 8;
`ifdef SHIFT_ADD_MUL_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  logic               Clk = 1'b0;
  logic               Rst;
  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] prdct;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] p;
  } vec_t;

  vec_t vecs[12];

  shift_add_mul #(.WIDTH(WIDTH)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .prdct (prdct)
  );

  always #5 Clk = ~Clk;

  function automatic int exp_latency(input logic [WIDTH-1:0] b);
    int msb_lat;
    msb_lat = 1;
    for (int i = 0; i < WIDTH; i++)
      if (b[i]) msb_lat = i + 1;
    return EARLY_EXIT ? msb_lat : WIDTH;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present operands and a start pulse; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit scramble);
    @(negedge Clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge Clk);
    #1;
    if (!scramble) start = 1'b0;
    checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done(input bit scramble, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 4*WIDTH) begin
      if (scramble) begin
        @(negedge Clk);
        A = WIDTH'($urandom);
        B = WIDTH'($urandom);
      end
      @(posedge Clk);
      #1;
      cycles++;
      if (done) seen = 1'b1;
      else checkOutput("busy_during_run", {31'b0, busy}, 32'd1);
    end
  endtask

  task automatic run_vector(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [2*WIDTH-1:0] p, input bit scramble);
    int cycles;
    bit seen;
    applyStimulus(a, b, scramble);
    wait_done(scramble, cycles, seen);
    start = 1'b0;
    checkOutput($sformatf("done_seen %0dx%0d", a, b), {31'b0, seen}, 32'd1);
    checkOutput($sformatf("latency %0dx%0d", a, b), cycles, exp_latency(b));
    checkOutput($sformatf("prdct %0dx%0d", a, b), {16'b0, prdct}, {16'b0, p});
    checkOutput("busy_at_done", {31'b0, busy}, 32'd0);
    @(posedge Clk);
    #1;
    checkOutput("done_pulse_width", {31'b0, done}, 32'd0);
    checkOutput("busy_stays_idle", {31'b0, busy}, 32'd0);
    checkOutput("prdct_hold", {16'b0, prdct}, {16'b0, p});
  endtask

  initial begin
    int  c1, c2;
    bit  s1, s2;
    bit  stray;

    Rst   = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;

    vecs[0]  = '{8'd13,  8'd11,  16'd143};
    vecs[1]  = '{8'd255, 8'd255, 16'd65025};
    vecs[2]  = '{8'd0,   8'd200, 16'd0};
    vecs[3]  = '{8'd1,   8'd1,   16'd1};
    vecs[4]  = '{8'd5,   8'd1,   16'd5};
    vecs[5]  = '{8'd9,   8'd0,   16'd0};
    vecs[6]  = '{8'd2,   8'h80,  16'd256};
    vecs[7]  = '{8'd200, 8'd3,   16'd600};
    vecs[8]  = '{8'd1,   8'd255, 16'd255};
    vecs[9]  = '{8'd255, 8'd2,   16'd510};
    vecs[10] = '{8'd128, 8'd128, 16'd16384};
    vecs[11] = '{8'd37,  8'd19,  16'd703};

    #12;
    checkOutput("reset_busy",  {31'b0, busy}, 32'd0);
    checkOutput("reset_done",  {31'b0, done}, 32'd0);
    checkOutput("reset_prdct", {16'b0, prdct}, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;

    foreach (vecs[i]) run_vector(vecs[i].a, vecs[i].b, vecs[i].p, 1'b0);

    $display("[TB] start held high with operands changing during RUN");
    run_vector(8'd7, 8'd9, 16'd63, 1'b1);

    $display("[TB] back-to-back start on the done cycle");
    applyStimulus(8'd6, 8'd6, 1'b0);
    wait_done(1'b0, c1, s1);
    checkOutput("b2b_first_done", {31'b0, s1}, 32'd1);
    checkOutput("b2b_first_prdct", {16'b0, prdct}, 32'd36);
    A = 8'd3;
    B = 8'd5;
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    checkOutput("b2b_accepted_busy", {31'b0, busy}, 32'd1);
    checkOutput("b2b_done_dropped", {31'b0, done}, 32'd0);
    checkOutput("b2b_old_prdct_held", {16'b0, prdct}, 32'd36);
    wait_done(1'b0, c2, s2);
    checkOutput("b2b_second_done", {31'b0, s2}, 32'd1);
    checkOutput("b2b_second_latency", c2, exp_latency(8'd5));
    checkOutput("b2b_second_prdct", {16'b0, prdct}, 32'd15);

    $display("[TB] asynchronous reset in the middle of a run");
    applyStimulus(8'd100, 8'd100, 1'b0);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    #2;
    Rst = 1'b0;
    #1;
    checkOutput("abort_busy",  {31'b0, busy}, 32'd0);
    checkOutput("abort_done",  {31'b0, done}, 32'd0);
    checkOutput("abort_prdct", {16'b0, prdct}, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    stray = 1'b0;
    repeat (12) begin
      @(posedge Clk);
      #1;
      if (done || busy) stray = 1'b1;
    end
    checkOutput("no_activity_after_abort", {31'b0, stray}, 32'd0);
    run_vector(8'd2, 8'd3, 16'd6, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
